sync_timing_gen: RTL
====================

Name: sync_timing_gen

Overview:
Upstream timing source for the pattern generator. Produces the per-line `sync` pulse and the per-frame `f_sync` pulse from a programmable line length and lines-per-frame. It also shadows the pattern configuration (mode, constant value, ramp deltas) at each frame start, so the pattern generator sees a stable configuration for a whole frame. Runs on the 16 ns master clock.

Parameters:
LEN_W, 13, width of line_len and pix_idx (line period up to 8191 clocks)
LINES_W, 8, width of lines_per_frame and line_idx

Ports:
clk  in  1  master clock, 16 ns period
rst  in  1  synchronous reset, active-high
en  in  1  run request; sampled only at frame boundaries while running
line_len  in  LEN_W  clocks per line (sync period)
lines_per_frame  in  LINES_W  lines (sync pulses) per frame
mode_in  in  3  pattern mode request
const_in  in  12  constant-mode value request
x_in  in  2  ramp deltaX request
y_in  in  2  ramp deltaY request
sync  out  1  one-clock pulse at start of every line
f_sync  out  1  one-clock pulse at start of every frame, coincident with that frame's first sync
pix_idx  out  LEN_W  position within line, 0..len_s-1
line_idx  out  LINES_W  line within frame, 0..lines_s-1
running  out  1  high while in RUN
mode_out  out  3  shadowed mode
const_out  out  12  shadowed constant
x_out  out  2  shadowed deltaX
y_out  out  2  shadowed deltaY

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - sync, f_sync, running = 0.
  - pix_idx, line_idx = 0.
  - mode_out=3'b000, const_out=0, x_out=0, y_out=0.
  - Internal len_s=2, lines_s=1.
  - rst has priority over every other event, including mid-line and mid-frame.
- FSM states: IDLE, RUN. All outputs are registered.
- Frame load, performed on IDLE->RUN and on every frame wrap that continues:
  - len_s <= max(line_len, 2).
  - lines_s <= max(lines_per_frame, 1).
  - mode_out, const_out, x_out, y_out <= their respective inputs.
  - Inputs that change mid-frame have no effect until the next frame load.
- IDLE:
  - Counters are held at 0 and no pulses are generated.
  - If en=1 at an edge: perform a frame load, go to RUN, and set pix_idx=0, line_idx=0, sync=1, f_sync=1, running=1 in the following cycle.
  - Latency from en sampled high to the first pulse is exactly 1 clock.
- RUN, at each edge:
  - If pix_idx < len_s-1: pix_idx+1.
  - Else (line end): pix_idx=0.
    - If line_idx < lines_s-1: line_idx+1, sync=1 next cycle.
    - Else (frame end), with en=1: perform a frame load, line_idx=0, sync=1, f_sync=1.
    - Else (frame end), with en=0: go to IDLE with running=0, no pulse, and shadow outputs held.
  - sync is high exactly in cycles where pix_idx==0 in RUN. f_sync is high exactly where pix_idx==0 and line_idx==0.
- Deasserting en mid-frame has no effect until the frame end; the frame always completes.
- Period rules:
  - sync period = len_s clocks.
  - f_sync period = len_s*lines_s clocks.
  - line_len of 0 or 1 behaves as 2.
  - lines_per_frame of 0 behaves as 1; every sync is then also an f_sync.
- Counters never exceed len_s-1 / lines_s-1, so there is no wrap-around beyond the configured limits.

Optional Feature:
- Macro SYNC_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0].
  - Reset value 0.
  - Increments by 1 in the same edge that raises f_sync, excluding the first frame after IDLE->RUN; wraps 16'hFFFF->0.
  - Holds its value in IDLE.
- Undefined: no port and no logic.

Decomposition:
- Shared package sync_pkg:
  - typedef of the state enum (IDLE, RUN).
  - Constants MIN_LINE_LEN=2, MIN_LINES=1.
  - Mode encodings: REGULAR=1, CONST=2, W1X1=3, B1X1=4, W2X2=5, B2X2=6, RAMP=7.
- One sub-module, sync_cfg_shadow, holds the frame-load registers: len_s, lines_s, mode_out, const_out, x_out, y_out, with a load strobe. The counters and FSM stay in the top.

Test Plan:
- Basic timing:
  - Stimulus: rst 2 clocks; line_len=6, lines_per_frame=3, en=1.
  - Required: first sync+f_sync 1 clock after en sampled; sync every 6 clocks; f_sync every 18 clocks; line_idx sequence 0,1,2,0.
- Mid-frame config change:
  - Stimulus: during a frame, change mode_in 1->7, x_in=2, y_in=2, line_len=10.
  - Required: mode_out, x_out, y_out and the 10-clock period take effect only at the next f_sync.
- Clamping:
  - Stimulus: line_len=0, lines_per_frame=0.
  - Required: sync every 2 clocks; f_sync on every sync.
- Stop at frame end:
  - Stimulus: deassert en at line 1, pix 3 (line_len=6, lines_per_frame=3).
  - Required: frame completes to line 2, pix 5; then running=0, no further pulses, counters 0.
- Reset mid-line:
  - Stimulus: assert rst at pix_idx=4.
  - Required: next cycle all outputs at reset values; with en=1 afterwards, a new frame starts 1 clock after rst deasserts.
- Long frames (SYNC_FRAME_CNT_EN defined):
  - Stimulus: line_len=4501, lines_per_frame=24, run 3 frames.
  - Required: sync spacing 4501 clocks; f_sync spacing 108024 clocks; frame_cnt=2 after the third f_sync.

Source files
------------

// File: rtl/sync_pkg.sv
// Shared types and constants for the sync timing generator and the pattern path it feeds.
package sync_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MIN_LINE_LEN = 2;
    localparam int MIN_LINES    = 1;

    localparam logic [2:0] REGULAR = 3'd1;
    localparam logic [2:0] CONST   = 3'd2;
    localparam logic [2:0] W1X1    = 3'd3;
    localparam logic [2:0] B1X1    = 3'd4;
    localparam logic [2:0] W2X2    = 3'd5;
    localparam logic [2:0] B2X2    = 3'd6;
    localparam logic [2:0] RAMP    = 3'd7;
endpackage

// File: rtl/sync_cfg_shadow.sv
// Frame-load shadow registers: timing limits and pattern configuration captured on a load strobe.
module sync_cfg_shadow
    import sync_pkg::*;
#(
    parameter int LEN_W   = 13,
    parameter int LINES_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [LEN_W-1:0]   i_line_len,
    input  logic [LINES_W-1:0] i_lines,
    input  logic [2:0]         i_mode,
    input  logic [11:0]        i_const,
    input  logic [1:0]         i_x,
    input  logic [1:0]         i_y,
    output logic [LEN_W-1:0]   o_len_s,
    output logic [LINES_W-1:0] o_lines_s,
    output logic [2:0]         o_mode,
    output logic [11:0]        o_const,
    output logic [1:0]         o_x,
    output logic [1:0]         o_y
);
    localparam logic [LEN_W-1:0]   LEN_MIN   = LEN_W'(MIN_LINE_LEN);
    localparam logic [LINES_W-1:0] LINES_MIN = LINES_W'(MIN_LINES);

    logic [LEN_W-1:0]   r_len_s;
    logic [LINES_W-1:0] r_lines_s;
    logic [2:0]         r_mode;
    logic [11:0]        r_const;
    logic [1:0]         r_x, r_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len_s   <= LEN_MIN;
            r_lines_s <= LINES_MIN;
            r_mode    <= 3'b000;
            r_const   <= '0;
            r_x       <= '0;
            r_y       <= '0;
        end else if (i_load) begin
            // Degenerate sizes are clamped so the counters always have a valid limit
            r_len_s   <= (i_line_len < LEN_MIN) ? LEN_MIN : i_line_len;
            r_lines_s <= (i_lines < LINES_MIN) ? LINES_MIN : i_lines;
            r_mode    <= i_mode;
            r_const   <= i_const;
            r_x       <= i_x;
            r_y       <= i_y;
        end
    end

    assign o_len_s   = r_len_s;
    assign o_lines_s = r_lines_s;
    assign o_mode    = r_mode;
    assign o_const   = r_const;
    assign o_x       = r_x;
    assign o_y       = r_y;
endmodule

// File: rtl/sync_timing_gen.sv
// Line/frame sync generator with per-frame config shadowing.
// Optional SYNC_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module sync_timing_gen
    import sync_pkg::*;
#(
    parameter int LEN_W   = 13,
    parameter int LINES_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [LEN_W-1:0]   line_len,
    input  logic [LINES_W-1:0] lines_per_frame,
    input  logic [2:0]         mode_in,
    input  logic [11:0]        const_in,
    input  logic [1:0]         x_in,
    input  logic [1:0]         y_in,
    output logic               sync,
    output logic               f_sync,
    output logic [LEN_W-1:0]   pix_idx,
    output logic [LINES_W-1:0] line_idx,
    output logic               running,
    output logic [2:0]         mode_out,
    output logic [11:0]        const_out,
    output logic [1:0]         x_out,
    output logic [1:0]         y_out
`ifdef SYNC_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);
    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
    localparam logic [LINES_W-1:0] LINES_ONE = LINES_W'(1);

    state_t             r_state, w_state_nxt;
    logic [LEN_W-1:0]   r_pix, w_pix_nxt;
    logic [LINES_W-1:0] r_line, w_line_nxt;
    logic               r_sync, w_sync_nxt;
    logic               r_fsync, w_fsync_nxt;
    logic               r_running, w_running_nxt;

    logic [LEN_W-1:0]   w_len_s;
    logic [LINES_W-1:0] w_lines_s;
    logic               w_line_end, w_frame_end, w_wrap, w_load;

    assign w_line_end  = (r_pix >= w_len_s - LEN_ONE);
    assign w_frame_end = (r_line >= w_lines_s - LINES_ONE);
    assign w_wrap      = (r_state == RUN) && w_line_end && w_frame_end && en;
    assign w_load      = ((r_state == IDLE) && en) || w_wrap;

    sync_cfg_shadow #(.LEN_W(LEN_W), .LINES_W(LINES_W)) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_line_len (line_len),
        .i_lines    (lines_per_frame),
        .i_mode     (mode_in),
        .i_const    (const_in),
        .i_x        (x_in),
        .i_y        (y_in),
        .o_len_s    (w_len_s),
        .o_lines_s  (w_lines_s),
        .o_mode     (mode_out),
        .o_const    (const_out),
        .o_x        (x_out),
        .o_y        (y_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pix     <= '0;
            r_line    <= '0;
            r_sync    <= 1'b0;
            r_fsync   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix     <= w_pix_nxt;
            r_line    <= w_line_nxt;
            r_sync    <= w_sync_nxt;
            r_fsync   <= w_fsync_nxt;
            r_running <= w_running_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_nxt     = '0;
        w_line_nxt    = '0;
        w_sync_nxt    = 1'b0;
        w_fsync_nxt   = 1'b0;
        w_running_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt   = RUN;
                    w_sync_nxt    = 1'b1;
                    w_fsync_nxt   = 1'b1;
                    w_running_nxt = 1'b1;
                end
            end
            RUN: begin
                w_running_nxt = 1'b1;
                if (!w_line_end) begin
                    w_pix_nxt  = r_pix + LEN_ONE;
                    w_line_nxt = r_line;
                end else if (!w_frame_end) begin
                    w_line_nxt = r_line + LINES_ONE;
                    w_sync_nxt = 1'b1;
                end else if (en) begin
                    w_sync_nxt  = 1'b1;
                    w_fsync_nxt = 1'b1;
                end else begin
                    // en is only honoured here, so a started frame always completes
                    w_state_nxt   = IDLE;
                    w_running_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sync     = r_sync;
    assign f_sync   = r_fsync;
    assign pix_idx  = r_pix;
    assign line_idx = r_line;
    assign running  = r_running;

`ifdef SYNC_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // The frame started from IDLE is not counted; only continuing wraps are
    always_ff @(posedge clk) begin
        if (rst) r_frame_cnt <= '0;
        else if (w_wrap) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif
endmodule
